// File: rtl/chart_sequencer.sv
// chart_sequencer -- steps through a multi-lane note chart one column per beat.
//
// A chart (NUM_LANES x CHART_LEN bits) is captured on `load`, then played
// column by column on `beat_tick` once `start` has been seen.  The current
// column (lane_now) and a WINDOW-column look-ahead (window) are registered so
// they update one cycle after the beat.  notes_left counts down by the notes
// in each departing column, saturating at zero.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   chart_in  [NL*CL]      lane L at [L*CHART_LEN +: CHART_LEN], column 0 = LSB
//   total_in  [CNT_W]      declared note count, captured on load
//   load/start/pause/beat_tick   single-cycle strobes (load wins over the rest)
//   lane_now  [NL]         notes in the current column
//   window    [NL*WINDOW]  lane L at [L*WINDOW +: WINDOW], bit k = column pos+k
//   position, notes_left   current column index / notes not yet passed
//   busy, done             busy in PLAYING/PAUSED; done pulses at chart end
//
// Build option: define CHART_SEQUENCER_LOOP_EN to make playback wrap back to
// column 0 (reloading notes_left) instead of stopping in DONE.

// Per-lane look-ahead: the lane's bits shifted down to the current column.
// Shifting past the end fills with zeros, which gives the "0 beyond the
// chart end" behaviour for free.
module chart_lane #(
  parameter int CHART_LEN = 100,
  parameter int WINDOW    = 8,
  parameter int PW        = 7
) (
  input  logic [CHART_LEN-1:0] bits,
  input  logic [PW-1:0]        pos,
  output logic [WINDOW-1:0]    win
);
  assign win = WINDOW'(bits >> pos);
endmodule

module chart_sequencer #(
  parameter int NUM_LANES = 3,
  parameter int CHART_LEN = 100,
  parameter int WINDOW    = 8,
  parameter int CNT_W     = 8,
  localparam int PW       = $clog2(CHART_LEN+1)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_LANES*CHART_LEN-1:0] chart_in,
  input  logic [CNT_W-1:0]              total_in,
  input  logic                          load,
  input  logic                          start,
  input  logic                          pause,
  input  logic                          beat_tick,
  output logic [NUM_LANES-1:0]          lane_now,
  output logic [NUM_LANES*WINDOW-1:0]   window,
  output logic [PW-1:0]                 position,
  output logic [CNT_W-1:0]              notes_left,
  output logic                          busy,
  output logic                          done
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOADED  = 3'd1;
  localparam logic [2:0] ST_PLAYING = 3'd2;
  localparam logic [2:0] ST_PAUSED  = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]                     state, nxt_state;
  logic [NUM_LANES*CHART_LEN-1:0] chart_q, nxt_chart;
  logic [PW-1:0]                  pos_q, nxt_pos;
  logic [CNT_W-1:0]               left_q, nxt_left;
  logic                           nxt_done;
  logic [CNT_W-1:0]               pc;
  logic [NUM_LANES*WINDOW-1:0]    nxt_win;
  logic [NUM_LANES-1:0]           nxt_lane;
`ifdef CHART_SEQUENCER_LOOP_EN
  logic [CNT_W-1:0]               total_q;
`endif

  // Outputs are computed from the *next* chart/position so the registered
  // copies line up with position in the same cycle.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    chart_lane #(.CHART_LEN(CHART_LEN), .WINDOW(WINDOW), .PW(PW)) u_lane (
      .bits (nxt_chart[l*CHART_LEN +: CHART_LEN]),
      .pos  (nxt_pos),
      .win  (nxt_win[l*WINDOW +: WINDOW])
    );
    assign nxt_lane[l] = nxt_win[l*WINDOW];
  end

  // Notes in the departing column are exactly the registered lane_now.
  always_comb begin
    pc = '0;
    for (int i = 0; i < NUM_LANES; i++) pc = pc + CNT_W'(lane_now[i]);
  end

  always_comb begin
    nxt_state = state;
    nxt_chart = chart_q;
    nxt_pos   = pos_q;
    nxt_left  = left_q;
    nxt_done  = 1'b0;
    if (load) begin
      nxt_chart = chart_in;
      nxt_pos   = '0;
      nxt_left  = total_in;
      nxt_state = ST_LOADED;
    end else begin
      case (state)
        ST_LOADED: if (start) nxt_state = ST_PLAYING;
        ST_PLAYING: begin
          if (beat_tick) begin
            nxt_left = (left_q > pc) ? left_q - pc : '0;
            if (pos_q == PW'(CHART_LEN-1)) begin
              nxt_done = 1'b1;
`ifdef CHART_SEQUENCER_LOOP_EN
              nxt_pos  = '0;
              nxt_left = total_q;
`else
              nxt_pos   = PW'(CHART_LEN);
              nxt_state = ST_DONE;
`endif
            end else begin
              nxt_pos = pos_q + 1'b1;
            end
          end
          // Advance first, then pause; reaching DONE takes precedence.
          if (pause && nxt_state == ST_PLAYING) nxt_state = ST_PAUSED;
        end
        ST_PAUSED: if (pause) nxt_state = ST_PLAYING;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      chart_q    <= '0;
      pos_q      <= '0;
      left_q     <= '0;
      done       <= 1'b0;
      lane_now   <= '0;
      window     <= '0;
    end else begin
      state      <= nxt_state;
      chart_q    <= nxt_chart;
      pos_q      <= nxt_pos;
      left_q     <= nxt_left;
      done       <= nxt_done;
      if (nxt_state == ST_DONE) begin
        lane_now <= '0;
        window   <= '0;
      end else begin
        lane_now <= nxt_lane;
        window   <= nxt_win;
      end
    end
  end

`ifdef CHART_SEQUENCER_LOOP_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   total_q <= '0;
    else if (load) total_q <= total_in;
  end
`endif

  assign position   = pos_q;
  assign notes_left = left_q;
  assign busy       = (state == ST_PLAYING) || (state == ST_PAUSED);

endmodule

// File: tb/tb_chart_sequencer.sv
// Bench for chart_sequencer: instance A uses the default 3x100 chart with an
// 8-column window, instance B a 3x4 chart with a 2-column window for the
// end-of-chart behaviour.  Expected observations are pushed to a scoreboard
// queue as stimulus is driven and popped when the outputs are sampled.
module tb_chart_sequencer;
  localparam int CA = 100, WA = 8, CB = 4, WB = 2;

  typedef struct packed {
    logic [7:0]  pos;
    logic [7:0]  left;
    logic [2:0]  lane;
    logic [23:0] win;
    logic        busy;
    logic        done;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;

  logic [3*CA-1:0] chart_a;
  logic [7:0]      total_a;
  logic            load_a, start_a, pause_a, beat_a;
  logic [2:0]      lane_a;
  logic [3*WA-1:0] win_a;
  logic [6:0]      pos_a;
  logic [7:0]      left_a;
  logic            busy_a, done_a;

  logic [3*CB-1:0] chart_b;
  logic [7:0]      total_b;
  logic            load_b, start_b, pause_b, beat_b;
  logic [2:0]      lane_b;
  logic [3*WB-1:0] win_b;
  logic [2:0]      pos_b;
  logic [7:0]      left_b;
  logic            busy_b, done_b;

  chart_sequencer dut_a (
    .clk(clk), .resetn(resetn), .chart_in(chart_a), .total_in(total_a),
    .load(load_a), .start(start_a), .pause(pause_a), .beat_tick(beat_a),
    .lane_now(lane_a), .window(win_a), .position(pos_a), .notes_left(left_a),
    .busy(busy_a), .done(done_a));

  chart_sequencer #(.CHART_LEN(CB), .WINDOW(WB)) dut_b (
    .clk(clk), .resetn(resetn), .chart_in(chart_b), .total_in(total_b),
    .load(load_b), .start(start_b), .pause(pause_b), .beat_tick(beat_b),
    .lane_now(lane_b), .window(win_b), .position(pos_b), .notes_left(left_b),
    .busy(busy_b), .done(done_b));

  obs_t sb[$];
  obs_t e, g;
  int   n_chk = 0, n_pass = 0;

  // Reference model for instance A
  logic [3*CA-1:0] m_chart;
  int              m_pos, m_left;
  logic            m_busy;

  function automatic obs_t model_a();
    obs_t o;
    o = '0;
    o.pos  = 8'(m_pos);
    o.left = 8'(m_left);
    o.busy = m_busy;
    for (int l = 0; l < 3; l++) begin
      if (m_pos < CA) o.lane[l] = m_chart[l*CA + m_pos];
      for (int k = 0; k < WA; k++)
        if (m_pos + k < CA) o.win[l*WA + k] = m_chart[l*CA + m_pos + k];
    end
    return o;
  endfunction

  function automatic obs_t got_a();
    obs_t o;
    o = '{pos: {1'b0, pos_a}, left: left_a, lane: lane_a, win: win_a,
          busy: busy_a, done: done_a};
    return o;
  endfunction

  function automatic obs_t got_b();
    obs_t o;
    o = '{pos: {5'b0, pos_b}, left: left_b, lane: lane_b, win: {18'b0, win_b},
          busy: busy_b, done: done_b};
    return o;
  endfunction

  function automatic obs_t mk(int p, int lf, logic [2:0] ln, logic [5:0] w,
                              logic b, logic d);
    obs_t o;
    o = '{pos: 8'(p), left: 8'(lf), lane: ln, win: {18'b0, w}, busy: b, done: d};
    return o;
  endfunction

  task automatic m_adv();
    int pc = 0;
    for (int l = 0; l < 3; l++) pc += int'(m_chart[l*CA + m_pos]);
    m_left = (m_left > pc) ? m_left - pc : 0;
    m_pos++;
  endtask

  task automatic m_reset();
    m_chart = '0; m_pos = 0; m_left = 0; m_busy = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    load_a = 0; start_a = 0; pause_a = 0; beat_a = 0;
    load_b = 0; start_b = 0; pause_b = 0; beat_b = 0;
  endtask

  task automatic test_reset();
    resetn = 0;
    load_a = 0; start_a = 0; pause_a = 0; beat_a = 0; chart_a = '0; total_a = 0;
    load_b = 0; start_b = 0; pause_b = 0; beat_b = 0; chart_b = '0; total_b = 0;
    m_reset();
    sb.push_back(model_a());
    sb.push_back(mk(0, 0, 3'b0, 6'b0, 0, 0));
    #2;
    e = sb.pop_front(); g = got_a(); n_chk++;
    if (g !== e) $display("FAIL reset_a: got %p exp %p", g, e); else n_pass++;
    e = sb.pop_front(); g = got_b(); n_chk++;
    if (g !== e) $display("FAIL reset_b: got %p exp %p", g, e); else n_pass++;
    tick(); tick();
    resetn = 1;
    tick();
  endtask

  task automatic test_load();
    for (int i = 0; i < 3*CA; i++) chart_a[i] = 1'($urandom_range(0, 1));
    chart_a[0] = 1'b1; chart_a[CA] = 1'b0; chart_a[2*CA] = 1'b0;
    total_a = 8'd5; load_a = 1;
    m_chart = chart_a; m_pos = 0; m_left = 5; m_busy = 0;
    sb.push_back(model_a());
    tick();
    e = sb.pop_front(); g = got_a(); n_chk++;
    if (g !== e) $display("FAIL load: got %p exp %p", g, e); else n_pass++;
    n_chk++;
    if (lane_a !== 3'b001) $display("FAIL load_lane: got %b exp 001", lane_a);
    else n_pass++;
  endtask

  task automatic test_start_beat();
    start_a = 1; m_busy = 1;
    sb.push_back(model_a());
    tick();
    e = sb.pop_front(); g = got_a(); n_chk++;
    if (g !== e) $display("FAIL start: got %p exp %p", g, e); else n_pass++;
    beat_a = 1; m_adv();
    sb.push_back(model_a());
    tick();
    e = sb.pop_front(); g = got_a(); n_chk++;
    if (g !== e) $display("FAIL first_beat: got %p exp %p", g, e); else n_pass++;
    n_chk++;
    if (pos_a !== 7'd1 || left_a !== 8'd4)
      $display("FAIL first_beat_cnt: got pos=%0d left=%0d exp pos=1 left=4", pos_a, left_a);
    else n_pass++;
  endtask

  task automatic test_pause_beat();
    for (int i = 0; i < 2; i++) begin
      beat_a = 1; m_adv(); sb.push_back(model_a()); tick();
      e = sb.pop_front(); g = got_a(); n_chk++;
      if (g !== e) $display("FAIL beat_to_3: got %p exp %p", g, e); else n_pass++;
    end
    pause_a = 1; beat_a = 1; m_adv();
    sb.push_back(model_a());
    tick();
    e = sb.pop_front(); g = got_a(); n_chk++;
    if (g !== e) $display("FAIL pause_beat: got %p exp %p", g, e); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      beat_a = 1; sb.push_back(model_a()); tick();
      e = sb.pop_front(); g = got_a(); n_chk++;
      if (g !== e || pos_a !== 7'd4) $display("FAIL paused_beat: got %p exp %p", g, e);
      else n_pass++;
    end
    pause_a = 1; sb.push_back(model_a()); tick();
    e = sb.pop_front(); g = got_a(); n_chk++;
    if (g !== e) $display("FAIL resume: got %p exp %p", g, e); else n_pass++;
  endtask

  task automatic test_load_priority();
    for (int i = 0; i < 3; i++) begin
      beat_a = 1; m_adv(); sb.push_back(model_a()); tick();
      e = sb.pop_front(); g = got_a(); n_chk++;
      if (g !== e) $display("FAIL beat_to_7: got %p exp %p", g, e); else n_pass++;
    end
    load_a = 1; beat_a = 1; total_a = 8'd9;
    m_pos = 0; m_left = 9; m_busy = 0;
    sb.push_back(model_a());
    tick();
    e = sb.pop_front(); g = got_a(); n_chk++;
    if (g !== e) $display("FAIL load_prio: got %p exp %p", g, e); else n_pass++;
  endtask

  task automatic test_saturation();
    chart_a[CA] = 1'b1;  // column 0 now holds two notes
    total_a = 8'd1; load_a = 1;
    m_chart = chart_a; m_pos = 0; m_left = 1; m_busy = 0;
    tick();
    start_a = 1; m_busy = 1; tick();
    beat_a = 1; m_adv();
    sb.push_back(model_a());
    tick();
    e = sb.pop_front(); g = got_a(); n_chk++;
    if (g !== e || left_a !== 8'd0) $display("FAIL saturate: got %p exp %p", g, e);
    else n_pass++;
  endtask

  task automatic test_chart_end();
    // op: 0 load, 1 start, 2 beat, 3 idle
    int   op[9] = '{0, 1, 2, 2, 2, 2, 3, 2, 1};
    obs_t ex[9];
    chart_b = {4'b1000, 4'b0011, 4'b0101}; total_b = 8'd6;
    ex[0] = mk(0, 6, 3'b011, 6'b001101, 0, 0);
    ex[1] = mk(0, 6, 3'b011, 6'b001101, 1, 0);
    ex[2] = mk(1, 4, 3'b010, 6'b000110, 1, 0);
    ex[3] = mk(2, 3, 3'b001, 6'b100001, 1, 0);
    ex[4] = mk(3, 2, 3'b100, 6'b010000, 1, 0);
`ifdef CHART_SEQUENCER_LOOP_EN
    ex[5] = mk(0, 6, 3'b011, 6'b001101, 1, 1);
    ex[6] = mk(0, 6, 3'b011, 6'b001101, 1, 0);
    ex[7] = mk(1, 4, 3'b010, 6'b000110, 1, 0);
    ex[8] = mk(1, 4, 3'b010, 6'b000110, 1, 0);
`else
    ex[5] = mk(4, 1, 3'b000, 6'b000000, 0, 1);
    ex[6] = mk(4, 1, 3'b000, 6'b000000, 0, 0);
    ex[7] = mk(4, 1, 3'b000, 6'b000000, 0, 0);
    ex[8] = mk(4, 1, 3'b000, 6'b000000, 0, 0);
`endif
    for (int i = 0; i < 9; i++) begin
      case (op[i])
        0: load_b = 1;
        1: start_b = 1;
        2: beat_b = 1;
        default: ;
      endcase
      sb.push_back(ex[i]);
      tick();
      e = sb.pop_front(); g = got_b(); n_chk++;
      if (g !== e) $display("FAIL chart_end step %0d: got %p exp %p", i, g, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    total_a = 8'd60; load_a = 1;
    m_chart = chart_a; m_pos = 0; m_left = 60; m_busy = 0;
    tick();
    start_a = 1; m_busy = 1; tick();
    for (int i = 0; i < 50; i++) begin
      beat_a = 1; m_adv(); tick();
    end
    sb.push_back(model_a());
    e = sb.pop_front(); g = got_a(); n_chk++;
    if (g !== e) $display("FAIL at_pos50: got %p exp %p", g, e); else n_pass++;
    resetn = 0; m_reset();
    sb.push_back(model_a());
    sb.push_back(mk(0, 0, 3'b0, 6'b0, 0, 0));
    #1;
    e = sb.pop_front(); g = got_a(); n_chk++;
    if (g !== e) $display("FAIL async_reset_a: got %p exp %p", g, e); else n_pass++;
    e = sb.pop_front(); g = got_b(); n_chk++;
    if (g !== e) $display("FAIL async_reset_b: got %p exp %p", g, e); else n_pass++;
    #1 resetn = 1;
    start_a = 1;
    sb.push_back(model_a());
    tick();
    beat_a = 1;
    sb.push_back(model_a());
    tick();
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front(); g = got_a(); n_chk++;
      if (g !== e) $display("FAIL start_after_reset: got %p exp %p", g, e); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_start_beat();
    test_pause_beat();
    test_load_priority();
    test_saturation();
    test_chart_end();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/chart_sequencer.md
CHART_SEQUENCER -- requirements
Module: chart_sequencer

Interface
REQ-001 SHALL have parameter NUM_LANES, default 3, meaning the number of note lanes (red, yellow, blue).
REQ-002 SHALL have parameter CHART_LEN, default 100, meaning the number of columns per chart.
REQ-003 SHALL have parameter WINDOW, default 8 (range 1..CHART_LEN), meaning the number of look-ahead columns presented for display.
REQ-004 SHALL have parameter CNT_W, default 8, meaning the note-counter width.
REQ-005 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port chart_in, input, NUM_LANES*CHART_LEN bits: lane L is at [L*CHART_LEN +: CHART_LEN], and column 0 is the LSB.
REQ-008 SHALL have port total_in, input, CNT_W bits: the declared note count of the chart.
REQ-009 SHALL have ports load, start, pause and beat_tick, inputs, 1 bit each, as single-cycle strobes.
REQ-010 SHALL have port lane_now, output, NUM_LANES bits: the current column.
REQ-011 SHALL have port window, output, NUM_LANES*WINDOW bits: lane L at [L*WINDOW +: WINDOW], bit k = column position+k, with 0 beyond the chart end.
REQ-012 SHALL have port position, output, $clog2(CHART_LEN+1) bits: the current column index.
REQ-013 SHALL have port notes_left, output, CNT_W bits: the count of notes not yet passed.
REQ-014 SHALL have ports busy and done, outputs, 1 bit each.

Function
REQ-015 SHALL implement states IDLE, LOADED, PLAYING, PAUSED and DONE.
REQ-016 SHALL, on load in any state, capture chart_in into an internal register, set position=0 and notes_left=total_in, and go to LOADED on the next edge.
REQ-017 SHALL give load priority over start, pause and beat_tick in the same cycle.
REQ-018 SHALL enter PLAYING from LOADED on start; start in IDLE, PLAYING or DONE SHALL be ignored.
REQ-019 SHALL, in PLAYING on beat_tick, increment position by 1 and decrement notes_left by popcount(lane_now) of the departing column, saturating at 0.
REQ-020 SHALL register lane_now, window and position so they reflect the new column one cycle after beat_tick.
REQ-021 SHALL, when beat_tick advances position to CHART_LEN, enter DONE, force lane_now=0 and window=0, and pulse done high for exactly one cycle.
REQ-022 SHALL toggle between PLAYING and PAUSED on pause; beat_tick in PAUSED SHALL be ignored.
REQ-023 SHALL, when pause and beat_tick arrive in the same PLAYING cycle, apply the advance first and then enter PAUSED.
REQ-024 SHALL drive busy=1 exactly in PLAYING and PAUSED.
REQ-025 SHALL leave notes_left unaffected by any mismatch between total_in and the actual chart bit count, other than by the saturation in REQ-019.
REQ-026 SHALL present lane_now = window column 0 whenever position < CHART_LEN.

Reset
REQ-027 SHALL, on resetn low, immediately force state=IDLE, chart register=0, position=0, notes_left=0, lane_now=0, window=0, busy=0 and done=0.
REQ-028 SHALL treat reset mid-playback as a full reset, requiring a new load before start.

Configuration
REQ-029 SHALL, with macro CHART_SEQUENCER_LOOP_EN defined, on reaching the chart end in PLAYING, wrap position to 0, reload notes_left from the captured total, pulse done for one cycle and remain in PLAYING.
REQ-030 SHALL, with CHART_SEQUENCER_LOOP_EN undefined, behave per REQ-021 and never wrap.

Verification
REQ-031 SHALL cover: reset, then load of a 3-lane chart with lane0 bit0=1 and total_in=5 -> LOADED, position=0, notes_left=5, lane_now=3'b001, busy=0.
REQ-032 SHALL cover: start, then 1 beat_tick -> position=1 and notes_left=4 one cycle later, with window shifted by 1.
REQ-033 SHALL cover: pause and beat_tick in the same cycle at position 3 -> position=4 and state PAUSED; further beat_ticks keep position=4.
REQ-034 SHALL cover: CHART_LEN=4 with 4 beat_ticks -> position=4, done high for 1 cycle, DONE state, lane_now=0 (LOOP_EN undefined); with LOOP_EN defined -> position=0, notes_left=total_in, still busy.
REQ-035 SHALL cover: load asserted together with beat_tick in PLAYING at position 7 -> LOADED with position=0.
REQ-036 SHALL cover: resetn pulsed low at position 50 -> all outputs 0 immediately, and start afterwards is ignored.
